// File: rtl/v_upd_sched_if.sv
// Request and update bus bundle for v_upd_sched.
// The scheduler connects through the slave modport; requesters and the v block use master.
interface v_upd_sched_if #(
  parameter int unsigned REQ_N  = 4,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned CMD_W  = 2,
  parameter int unsigned KEY_W  = 16,
  parameter int unsigned SIZE_W = 8
);
  localparam int unsigned SRC_W = $clog2(REQ_N);

  logic [REQ_N-1:0]        i_req_vld;
  logic [REQ_N-1:0]        o_req_rdy;
  logic [REQ_N*ID_W-1:0]   i_req_prod_id;
  logic [REQ_N*CMD_W-1:0]  i_req_cmd;
  logic [REQ_N*KEY_W-1:0]  i_req_key;
  logic [REQ_N*SIZE_W-1:0] i_req_size;
  logic                    i_busy;
  logic                    o_upd_vld_r;
  logic [ID_W-1:0]         o_upd_prod_id_r;
  logic [CMD_W-1:0]        o_upd_cmd_r;
  logic [KEY_W-1:0]        o_upd_key_r;
  logic [SIZE_W-1:0]       o_upd_size_r;
  logic [SRC_W-1:0]        o_upd_src_r;
  logic                    o_idle_r;

  modport master (
    output i_req_vld, i_req_prod_id, i_req_cmd, i_req_key, i_req_size, i_busy,
    input  o_req_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r,
    input  o_upd_size_r, o_upd_src_r, o_idle_r
  );

  modport slave (
    input  i_req_vld, i_req_prod_id, i_req_cmd, i_req_key, i_req_size, i_busy,
    output o_req_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r,
    output o_upd_size_r, o_upd_src_r, o_idle_r
  );
endinterface

// File: rtl/v_upd_sched.sv
// Update-bus scheduler: per-requester FIFOs, round-robin arbitration onto the v update bus,
// issue hold while v is busy, and a same-product-id spacing window.
module v_upd_sched #(
  parameter int unsigned REQ_N  = 4,
  parameter int unsigned FIFO_D = 4,
  parameter int unsigned HAZ_N  = 4,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned CMD_W  = 2,
  parameter int unsigned KEY_W  = 16,
  parameter int unsigned SIZE_W = 8
) (
  input logic          clk,
  input logic          rst,
  v_upd_sched_if.slave bus
);
  localparam int unsigned SRC_W = $clog2(REQ_N);
  localparam int unsigned AW    = $clog2(FIFO_D);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned ENT_W = ID_W + CMD_W + KEY_W + SIZE_W;
  localparam int unsigned HAZ_L = (HAZ_N > 0) ? HAZ_N : 1;

  logic [ENT_W-1:0] mem_q [REQ_N][FIFO_D];
  logic [ENT_W-1:0] mem_d [REQ_N][FIFO_D];
  logic [PW-1:0]    wr_ptr_q [REQ_N];
  logic [PW-1:0]    wr_ptr_d [REQ_N];
  logic [PW-1:0]    rd_ptr_q [REQ_N];
  logic [PW-1:0]    rd_ptr_d [REQ_N];
  logic [ENT_W-1:0] head   [REQ_N];
  logic [ENT_W-1:0] in_ent [REQ_N];
  logic [REQ_N-1:0] full, empty, push, pop, elig, haz_hit;

  logic [HAZ_L-1:0] haz_vld_q, haz_vld_d;
  logic [ID_W-1:0]  haz_id_q [HAZ_L];
  logic [ID_W-1:0]  haz_id_d [HAZ_L];

  logic [SRC_W-1:0] last_q, last_d;
  logic [SRC_W-1:0] win;
  logic             gnt;
  logic             all_empty_nxt;

  logic             upd_vld_q, upd_vld_d;
  logic [ENT_W-1:0] upd_ent_q, upd_ent_d;
  logic [SRC_W-1:0] upd_src_q, upd_src_d;
  logic             idle_q, idle_d;

  // FIFO status, head entries and eligibility per requester
  always_comb begin
    for (int r = 0; r < REQ_N; r++) begin
      in_ent[r] = {bus.i_req_prod_id[r*ID_W +: ID_W], bus.i_req_cmd[r*CMD_W +: CMD_W],
                   bus.i_req_key[r*KEY_W +: KEY_W], bus.i_req_size[r*SIZE_W +: SIZE_W]};
      full[r]   = (wr_ptr_q[r] ^ rd_ptr_q[r]) == PW'(FIFO_D);
      empty[r]  = wr_ptr_q[r] == rd_ptr_q[r];
      head[r]   = mem_q[r][rd_ptr_q[r][AW-1:0]];
      push[r]   = bus.i_req_vld[r] & ~full[r];
      haz_hit[r] = 1'b0;
      for (int unsigned k = 0; k < HAZ_L; k++) begin
        if ((HAZ_N != 0) && haz_vld_q[k] && (haz_id_q[k] == head[r][ENT_W-1 -: ID_W])) begin
          haz_hit[r] = 1'b1;
        end
      end
      elig[r] = ~empty[r] & ~bus.i_busy & ~haz_hit[r];
    end
  end

  // Round-robin search starting one past the last winner
  always_comb begin
    logic [SRC_W-1:0] idx;
    idx = '0;
    gnt = 1'b0;
    win = '0;
    for (int unsigned i = 1; i <= REQ_N; i++) begin
      idx = SRC_W'((32'(last_q) + i) % REQ_N);
      if (!gnt && elig[idx]) begin
        gnt = 1'b1;
        win = idx;
      end
    end
    pop = '0;
    if (gnt) pop[win] = 1'b1;
    last_d = gnt ? win : last_q;
  end

  always_comb begin
    mem_d         = mem_q;
    all_empty_nxt = 1'b1;
    for (int r = 0; r < REQ_N; r++) begin
      wr_ptr_d[r] = wr_ptr_q[r] + PW'(push[r]);
      rd_ptr_d[r] = rd_ptr_q[r] + PW'(pop[r]);
      if (push[r]) mem_d[r][wr_ptr_q[r][AW-1:0]] = in_ent[r];
      if (wr_ptr_d[r] != rd_ptr_d[r]) all_empty_nxt = 1'b0;
    end

    // Window slot 0 records this cycle's issue; idle cycles push an invalid slot
    haz_vld_d[0] = gnt;
    haz_id_d[0]  = gnt ? head[win][ENT_W-1 -: ID_W] : '0;
    for (int unsigned k = 1; k < HAZ_L; k++) begin
      haz_vld_d[k] = haz_vld_q[k-1];
      haz_id_d[k]  = haz_id_q[k-1];
    end

    upd_vld_d = gnt;
    upd_ent_d = gnt ? head[win] : upd_ent_q;
    upd_src_d = gnt ? win : upd_src_q;
    idle_d    = all_empty_nxt & ~gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REQ_N; r++) begin
        wr_ptr_q[r] <= '0;
        rd_ptr_q[r] <= '0;
      end
      for (int unsigned k = 0; k < HAZ_L; k++) haz_id_q[k] <= '0;
      haz_vld_q <= '0;
      last_q    <= SRC_W'(REQ_N - 1);
      upd_vld_q <= 1'b0;
      upd_ent_q <= '0;
      upd_src_q <= '0;
      idle_q    <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      haz_id_q  <= haz_id_d;
      haz_vld_q <= haz_vld_d;
      last_q    <= last_d;
      upd_vld_q <= upd_vld_d;
      upd_ent_q <= upd_ent_d;
      upd_src_q <= upd_src_d;
      idle_q    <= idle_d;
    end
  end

  // Storage needs no reset; pointers alone define occupancy
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.o_req_rdy       = ~full;
  assign bus.o_upd_vld_r     = upd_vld_q;
  assign bus.o_upd_prod_id_r = upd_ent_q[ENT_W-1 -: ID_W];
  assign bus.o_upd_cmd_r     = upd_ent_q[KEY_W+SIZE_W +: CMD_W];
  assign bus.o_upd_key_r     = upd_ent_q[SIZE_W +: KEY_W];
  assign bus.o_upd_size_r    = upd_ent_q[SIZE_W-1:0];
  assign bus.o_upd_src_r     = upd_src_q;
  assign bus.o_idle_r        = idle_q;
endmodule

// File: tb/tb_v_upd_sched.sv
// Bench for v_upd_sched: directed scenarios plus random traffic against a queue-based model.
module tb_v_upd_sched;
  localparam int unsigned REQ_N  = 4;
  localparam int unsigned FIFO_D = 4;
  localparam int unsigned HAZ_N  = 4;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned CMD_W  = 2;
  localparam int unsigned KEY_W  = 16;
  localparam int unsigned SIZE_W = 8;
  localparam int unsigned ENT_W  = 34;
  localparam int unsigned OBS_W  = 1 + 2 + ENT_W + 1 + REQ_N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  v_upd_sched_if #(.REQ_N(REQ_N), .ID_W(ID_W), .CMD_W(CMD_W), .KEY_W(KEY_W), .SIZE_W(SIZE_W))
    bus ();
  v_upd_sched_if #(.REQ_N(REQ_N), .ID_W(ID_W), .CMD_W(CMD_W), .KEY_W(KEY_W), .SIZE_W(SIZE_W))
    bus0 ();

  v_upd_sched #(.REQ_N(REQ_N), .FIFO_D(FIFO_D), .HAZ_N(HAZ_N), .ID_W(ID_W), .CMD_W(CMD_W),
                .KEY_W(KEY_W), .SIZE_W(SIZE_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  v_upd_sched #(.REQ_N(REQ_N), .FIFO_D(FIFO_D), .HAZ_N(0), .ID_W(ID_W), .CMD_W(CMD_W),
                .KEY_W(KEY_W), .SIZE_W(SIZE_W)) dut_h0 (.clk(clk), .rst(rst), .bus(bus0));

  // Reference model: one queue per requester, last issue cycle per id
  logic [ENT_W-1:0] mq [REQ_N][$];
  int               m_last;
  int               m_issue [256];
  int               cyc;
  logic             e_vld;
  logic [1:0]       e_src;
  logic [ENT_W-1:0] e_ent;
  logic             e_idle;
  logic [REQ_N-1:0] e_rdy;
  logic [ENT_W-1:0] drv_ent [REQ_N];
  int               nvec;
  int               nerr;

  function automatic logic [OBS_W-1:0] obs();
    return {bus.o_upd_vld_r, bus.o_upd_src_r, bus.o_upd_prod_id_r, bus.o_upd_cmd_r,
            bus.o_upd_key_r, bus.o_upd_size_r, bus.o_idle_r, bus.o_req_rdy};
  endfunction

  function automatic logic [OBS_W-1:0] expv();
    return {e_vld, e_src, e_ent, e_idle, e_rdy};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < REQ_N; r++) mq[r].delete();
    m_last = REQ_N - 1;
    for (int i = 0; i < 256; i++) m_issue[i] = -1000;
    e_vld  = 1'b0;
    e_src  = '0;
    e_ent  = '0;
    e_idle = 1'b1;
    e_rdy  = '1;
  endtask

  // Drives one cycle (from a negedge), advances the model, returns at the next negedge
  task automatic tick(input logic [REQ_N-1:0] vld, input logic busy, input logic rst_in);
    logic [REQ_N-1:0] acc;
    bit g;
    int w;
    int r;
    rst = rst_in;
    bus.i_req_vld = vld;
    bus.i_busy = busy;
    for (int k = 0; k < REQ_N; k++) begin
      bus.i_req_prod_id[k*ID_W +: ID_W]   = drv_ent[k][33:26];
      bus.i_req_cmd[k*CMD_W +: CMD_W]     = drv_ent[k][25:24];
      bus.i_req_key[k*KEY_W +: KEY_W]     = drv_ent[k][23:8];
      bus.i_req_size[k*SIZE_W +: SIZE_W]  = drv_ent[k][7:0];
    end
    if (rst_in) begin
      model_reset();
    end else begin
      g = 0;
      w = 0;
      if (!busy) begin
        for (int i = 1; i <= REQ_N; i++) begin
          r = (m_last + i) % REQ_N;
          if (!g && mq[r].size() > 0) begin
            if (cyc - m_issue[mq[r][0][33:26]] > int'(HAZ_N)) begin
              g = 1;
              w = r;
            end
          end
        end
      end
      for (int k = 0; k < REQ_N; k++) acc[k] = vld[k] && (mq[k].size() < FIFO_D);
      if (g) begin
        e_ent = mq[w].pop_front();
        e_src = w[1:0];
        m_last = w;
        m_issue[e_ent[33:26]] = cyc;
      end
      for (int k = 0; k < REQ_N; k++) if (acc[k]) mq[k].push_back(drv_ent[k]);
      e_vld  = g;
      e_idle = !g;
      for (int k = 0; k < REQ_N; k++) begin
        if (mq[k].size() != 0) e_idle = 1'b0;
        e_rdy[k] = mq[k].size() < FIFO_D;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick('0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    nvec++;
    if (obs() !== expv()) begin
      nerr++;
      $display("FAIL reset_model got=%h want=%h", obs(), expv());
    end
    nvec++;
    if ({bus.o_upd_vld_r, bus.o_idle_r, bus.o_req_rdy, bus.o_upd_src_r, bus.o_upd_prod_id_r}
        !== {1'b0, 1'b1, 4'hf, 2'd0, 8'd0}) begin
      nerr++;
      $display("FAIL reset_values vld=%b idle=%b rdy=%b src=%0d id=%0d want 0 1 1111 0 0",
               bus.o_upd_vld_r, bus.o_idle_r, bus.o_req_rdy, bus.o_upd_src_r,
               bus.o_upd_prod_id_r);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < REQ_N; r++) drv_ent[r] = {8'(r*16+k+1), 2'(k), 16'(r*256+k), 8'(k)};
      tick(4'hf, 1'b1, 1'b0);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL rr_fill k=%0d got=%h want=%h", k, obs(), expv());
      end
    end
    for (int c = 0; c < 16; c++) begin
      tick('0, 1'b0, 1'b0);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL rr_model c=%0d got=%h want=%h", c, obs(), expv());
      end
      nvec++;
      if (!(bus.o_upd_vld_r === 1'b1 && bus.o_upd_src_r === 2'(c % 4))) begin
        nerr++;
        $display("FAIL rr_order c=%0d vld=%b src=%0d want vld=1 src=%0d",
                 c, bus.o_upd_vld_r, bus.o_upd_src_r, c % 4);
      end
    end
    tick('0, 1'b0, 1'b0);
    nvec++;
    if (bus.o_idle_r !== 1'b1 || bus.o_upd_vld_r !== 1'b0) begin
      nerr++;
      $display("FAIL rr_idle idle=%b vld=%b want 1 0", bus.o_idle_r, bus.o_upd_vld_r);
    end
  endtask

  task automatic test_hazard();
    int t_iss[$];
    int t0_iss[$];
    do_reset();
    drv_ent[0] = {8'd5, 2'd1, 16'h1234, 8'd7};
    bus0.i_busy = 1'b0;
    bus0.i_req_prod_id = {24'd0, 8'd5};
    for (int c = 0; c < 30; c++) begin
      bus0.i_req_vld = (c < 3) ? 4'b0001 : 4'b0000;
      tick((c < 3) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL haz_model c=%0d got=%h want=%h", c, obs(), expv());
      end
      if (bus.o_upd_vld_r === 1'b1) t_iss.push_back(c);
      if (bus0.o_upd_vld_r === 1'b1) t0_iss.push_back(c);
    end
    nvec++;
    if (t_iss.size() != 3 || t_iss[0] != 1 || t_iss[1] != 6 || t_iss[2] != 11) begin
      nerr++;
      $display("FAIL haz_spacing issues=%p want '{1,6,11}", t_iss);
    end
    nvec++;
    if (t0_iss.size() != 3 || t0_iss[0] != 1 || t0_iss[1] != 2 || t0_iss[2] != 3) begin
      nerr++;
      $display("FAIL haz0_spacing issues=%p want '{1,2,3}", t0_iss);
    end
  endtask

  task automatic test_hazard_bypass();
    do_reset();
    drv_ent[0] = {8'd5, 2'd0, 16'h0005, 8'd1};
    tick(4'b0001, 1'b0, 1'b0);
    tick(4'b0001, 1'b0, 1'b0);
    drv_ent[1] = {8'd6, 2'd2, 16'h0006, 8'd2};
    tick(4'b0010, 1'b0, 1'b0);
    nvec++;
    if (bus.o_upd_vld_r !== 1'b0) begin
      nerr++;
      $display("FAIL bypass_blocked vld=%b want 0", bus.o_upd_vld_r);
    end
    tick('0, 1'b0, 1'b0);
    nvec++;
    if ({bus.o_upd_vld_r, bus.o_upd_src_r, bus.o_upd_prod_id_r} !== {1'b1, 2'd1, 8'd6}) begin
      nerr++;
      $display("FAIL bypass_issue vld=%b src=%0d id=%0d want 1 1 6",
               bus.o_upd_vld_r, bus.o_upd_src_r, bus.o_upd_prod_id_r);
    end
    for (int c = 0; c < 8; c++) begin
      tick('0, 1'b0, 1'b0);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL bypass_model c=%0d got=%h want=%h", c, obs(), expv());
      end
    end
  endtask

  task automatic test_busy_hold();
    int n_iss;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      for (int r = 0; r < REQ_N; r++) drv_ent[r] = {8'($urandom_range(0, 7)), 26'($urandom)};
      tick((c < 5) ? 4'hf : 4'h0, 1'b1, 1'b0);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL busy_model c=%0d got=%h want=%h", c, obs(), expv());
      end
      nvec++;
      if (bus.o_upd_vld_r !== 1'b0) begin
        nerr++;
        $display("FAIL busy_novld c=%0d vld=%b want 0", c, bus.o_upd_vld_r);
      end
      if (c == 2 || c == 3) begin
        nvec++;
        if (bus.o_req_rdy !== ((c == 2) ? 4'hf : 4'h0)) begin
          nerr++;
          $display("FAIL busy_rdy c=%0d rdy=%b want %b", c, bus.o_req_rdy,
                   (c == 2) ? 4'hf : 4'h0);
        end
      end
    end
    n_iss = 0;
    for (int c = 0; c < 90; c++) begin
      tick('0, 1'b0, 1'b0);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL busy_drain c=%0d got=%h want=%h", c, obs(), expv());
      end
      if (bus.o_upd_vld_r === 1'b1) n_iss++;
    end
    nvec++;
    if (n_iss != 16 || bus.o_idle_r !== 1'b1) begin
      nerr++;
      $display("FAIL busy_count issues=%0d idle=%b want 16 1", n_iss, bus.o_idle_r);
    end
  endtask

  task automatic test_full_boundary();
    int n_iss;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv_ent[0] = {8'(40+k), 2'(k), 16'(k), 8'(k)};
      tick(4'b0001, 1'b1, 1'b0);
    end
    nvec++;
    if (bus.o_req_rdy[0] !== 1'b0) begin
      nerr++;
      $display("FAIL full_rdy rdy0=%b want 0", bus.o_req_rdy[0]);
    end
    drv_ent[0] = {8'd99, 2'd3, 16'hbeef, 8'd9};
    tick(4'b0001, 1'b0, 1'b0);
    nvec++;
    if ({bus.o_req_rdy[0], bus.o_upd_vld_r, bus.o_upd_src_r, bus.o_upd_prod_id_r}
        !== {1'b1, 1'b1, 2'd0, 8'd40}) begin
      nerr++;
      $display("FAIL full_pop rdy0=%b vld=%b src=%0d id=%0d want 1 1 0 40", bus.o_req_rdy[0],
               bus.o_upd_vld_r, bus.o_upd_src_r, bus.o_upd_prod_id_r);
    end
    n_iss = 0;
    for (int c = 0; c < 10; c++) begin
      tick('0, 1'b0, 1'b0);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL full_model c=%0d got=%h want=%h", c, obs(), expv());
      end
      if (bus.o_upd_vld_r === 1'b1) n_iss++;
    end
    nvec++;
    if (n_iss != 3) begin
      nerr++;
      $display("FAIL full_count issues=%0d want 3", n_iss);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < REQ_N; r++) drv_ent[r] = {8'(100+r*8+k), 26'($urandom)};
      tick((k < 3) ? 4'b0011 : 4'b0001, 1'b1, 1'b0);
    end
    tick('0, 1'b1, 1'b1);
    nvec++;
    if ({bus.o_upd_vld_r, bus.o_idle_r, bus.o_req_rdy} !== {1'b0, 1'b1, 4'hf}) begin
      nerr++;
      $display("FAIL rstmid_state vld=%b idle=%b rdy=%b want 0 1 1111",
               bus.o_upd_vld_r, bus.o_idle_r, bus.o_req_rdy);
    end
    for (int r = 0; r < REQ_N; r++) drv_ent[r] = {8'(200+r), 26'($urandom)};
    tick(4'hf, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    nvec++;
    if ({bus.o_upd_vld_r, bus.o_upd_src_r} !== {1'b1, 2'd0}) begin
      nerr++;
      $display("FAIL rstmid_first vld=%b src=%0d want 1 0", bus.o_upd_vld_r, bus.o_upd_src_r);
    end
    for (int c = 0; c < 8; c++) begin
      tick('0, 1'b0, 1'b0);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL rstmid_model c=%0d got=%h want=%h", c, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    logic [REQ_N-1:0] v;
    logic             b;
    logic             rs;
    do_reset();
    for (int c = 0; c < 700; c++) begin
      for (int r = 0; r < REQ_N; r++) drv_ent[r] = {8'($urandom_range(0, 5)), 26'($urandom)};
      v  = (c < 640) ? REQ_N'($urandom) : '0;
      b  = ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 199) == 0);
      tick(v, b, rs);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL random c=%0d got=%h want=%h", c, obs(), expv());
      end
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    cyc  = 0;
    bus.i_req_vld = '0;
    bus.i_busy = 1'b0;
    bus.i_req_prod_id = '0;
    bus.i_req_cmd = '0;
    bus.i_req_key = '0;
    bus.i_req_size = '0;
    bus0.i_req_vld = '0;
    bus0.i_busy = 1'b0;
    bus0.i_req_prod_id = '0;
    bus0.i_req_cmd = '0;
    bus0.i_req_key = '0;
    bus0.i_req_size = '0;
    for (int r = 0; r < REQ_N; r++) drv_ent[r] = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_hazard();
    test_hazard_bypass();
    test_busy_hold();
    test_full_boundary();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout nvec=%0d nerr=%0d", nvec, nerr);
    $fatal(1, "time limit");
  end
endmodule
